// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types: per-register control commands and hazard-controller state.
// Consumed by pipeline_hazard_ctrl and its load-use detector.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CONTINUE = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2
    } pipeline_control_t;

    typedef logic [1:0] hazard_state_t;

    localparam hazard_state_t RUN        = 2'd0;
    localparam hazard_state_t LOAD_STALL = 2'd1;
    localparam hazard_state_t MEM_WAIT   = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    function automatic logic reg_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the decode instruction reads the register a load in
// execute is about to write. x0 never creates a dependency.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] rd,
    input  logic       mem_read,
    output logic       loaduse
);

    assign loaduse = mem_read && (rd != REG_X0) &&
                     (reg_match(uses_rs1, rs1, rd) || reg_match(uses_rs2, rs2, rd));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory waits.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int COUNT_WIDTH     = 32
)
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4:0]             dec_rs1_i,
    input  logic [4:0]             dec_rs2_i,
    input  logic                   dec_uses_rs1_i,
    input  logic                   dec_uses_rs2_i,
    input  logic [4:0]             ex_rd_i,
    input  logic                   ex_mem_read_i,
    input  logic                   ex_branch_taken_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ready_i,
    output pipeline_control_t      fetch_ctrl_o,
    output pipeline_control_t      decode_ctrl_o,
    output pipeline_control_t      execute_ctrl_o,
    output pipeline_control_t      memory_ctrl_o,
    output logic                   pc_hold_o,
    output logic [COUNT_WIDTH-1:0] stall_count_o,
    output logic [COUNT_WIDTH-1:0] flush_count_o,
    output hazard_state_t          dbg_state_o
);

    localparam logic [1:0] RELOAD = 2'(LOAD_USE_STALLS - 1);

    logic          memwait;
    logic          loaduse;
    hazard_state_t state_q, state_d;
    logic [1:0]    count_q, count_d;

    load_use_detect u_load_use_detect (
        .rs1      (dec_rs1_i),
        .rs2      (dec_rs2_i),
        .uses_rs1 (dec_uses_rs1_i),
        .uses_rs2 (dec_uses_rs2_i),
        .rd       (ex_rd_i),
        .mem_read (ex_mem_read_i),
        .loaduse  (loaduse)
    );

    assign memwait     = mem_req_i && !mem_ready_i;
    assign dbg_state_o = state_q;

    always_comb begin
        fetch_ctrl_o   = CONTINUE;
        decode_ctrl_o  = CONTINUE;
        execute_ctrl_o = CONTINUE;
        memory_ctrl_o  = CONTINUE;
        pc_hold_o      = 1'b0;
        state_d        = state_q;
        count_d        = count_q;
        if (rst_i) begin
            fetch_ctrl_o   = FLUSH;
            decode_ctrl_o  = FLUSH;
            execute_ctrl_o = FLUSH;
            memory_ctrl_o  = FLUSH;
            pc_hold_o      = 1'b1;
            state_d        = RUN;
            count_d        = 2'd0;
        end else if (memwait) begin
            // The remaining load-stall count is left untouched so it resumes after the wait.
            fetch_ctrl_o   = STALL;
            decode_ctrl_o  = STALL;
            execute_ctrl_o = STALL;
            memory_ctrl_o  = FLUSH;
            pc_hold_o      = 1'b1;
            state_d        = MEM_WAIT;
        end else if (ex_branch_taken_i) begin
            // The stalled decode instruction is discarded, so any pending load stall dies with it.
            fetch_ctrl_o  = FLUSH;
            decode_ctrl_o = FLUSH;
            state_d       = RUN;
            count_d       = 2'd0;
        end else if (state_q == LOAD_STALL) begin
            fetch_ctrl_o  = STALL;
            decode_ctrl_o = FLUSH;
            pc_hold_o     = 1'b1;
            count_d       = count_q - 2'd1;
            state_d       = (count_q <= 2'd1) ? RUN : LOAD_STALL;
        end else begin
            if (loaduse) begin
                fetch_ctrl_o  = STALL;
                decode_ctrl_o = FLUSH;
                pc_hold_o     = 1'b1;
            end
            if (count_q != 2'd0) begin
                state_d = LOAD_STALL;
            end else if (loaduse && (RELOAD != 2'd0)) begin
                state_d = LOAD_STALL;
                count_d = RELOAD;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [COUNT_WIDTH-1:0] stall_cnt_q;
    logic [COUNT_WIDTH-1:0] flush_cnt_q;
    logic                   flush_win;

    assign flush_win = ex_branch_taken_i && !memwait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold_o) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_win) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
`else
    assign stall_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controller instances (1 and 3 load-use stalls, 32- and 4-bit counters)
// share stimulus and are compared every cycle against a stall/wait bookkeeping model.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, req, rdy;

    pipeline_control_t f0, d0, e0, m0, f1, d1, e1, m1;
    logic              h0, h1;
    logic [31:0]       sc0, fc0;
    logic [3:0]        sc1, fc1;
    hazard_state_t     st0, st1;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: pending forced-stall cycles, wait flag, event tallies.
    int              pend[2];
    bit              waiting[2];
    longint unsigned scnt[2], fcnt[2];
    int              npend[2];
    bit              nwait[2];
    longint unsigned nscnt[2], nfcnt[2];
    int              lval[2] = '{1, 3};
    bit              counters_valid = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_STALLS(1), .COUNT_WIDTH(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
        .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2), .ex_rd_i(rd), .ex_mem_read_i(mr),
        .ex_branch_taken_i(br), .mem_req_i(req), .mem_ready_i(rdy),
        .fetch_ctrl_o(f0), .decode_ctrl_o(d0), .execute_ctrl_o(e0), .memory_ctrl_o(m0),
        .pc_hold_o(h0), .stall_count_o(sc0), .flush_count_o(fc0), .dbg_state_o(st0)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALLS(3), .COUNT_WIDTH(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
        .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2), .ex_rd_i(rd), .ex_mem_read_i(mr),
        .ex_branch_taken_i(br), .mem_req_i(req), .mem_ready_i(rdy),
        .fetch_ctrl_o(f1), .decode_ctrl_o(d1), .execute_ctrl_o(e1), .memory_ctrl_o(m1),
        .pc_hold_o(h1), .stall_count_o(sc1), .flush_count_o(fc1), .dbg_state_o(st1)
    );

    task automatic quiet();
        rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    // Called at the negedge with inputs driven: checks outputs, computes next model state.
    task automatic evaluate(input string tag);
        logic [8:0]  exp_ctrl, act_ctrl;
        logic [31:0] exp_sc, exp_fc, act_sc, act_fc;
        bit          lu, mw, fl, hold;
        #1;
        lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        mw = req && !rdy;
        for (int k = 0; k < 2; k++) begin
            npend[k] = pend[k];
            nwait[k] = waiting[k];
            fl = 1'b0;
            if (rst) begin
                exp_ctrl = {FLUSH, FLUSH, FLUSH, FLUSH, 1'b1};
                npend[k] = 0;
                nwait[k] = 1'b0;
            end else if (mw) begin
                exp_ctrl = {STALL, STALL, STALL, FLUSH, 1'b1};
                nwait[k] = 1'b1;
            end else if (br) begin
                exp_ctrl = {FLUSH, FLUSH, CONTINUE, CONTINUE, 1'b0};
                npend[k] = 0;
                nwait[k] = 1'b0;
                fl = 1'b1;
            end else if (pend[k] > 0 && !waiting[k]) begin
                exp_ctrl = {STALL, FLUSH, CONTINUE, CONTINUE, 1'b1};
                npend[k] = pend[k] - 1;
            end else begin
                nwait[k] = 1'b0;
                if (lu) begin
                    exp_ctrl = {STALL, FLUSH, CONTINUE, CONTINUE, 1'b1};
                    if (pend[k] == 0) npend[k] = lval[k] - 1;
                end else begin
                    exp_ctrl = {CONTINUE, CONTINUE, CONTINUE, CONTINUE, 1'b0};
                end
            end
            hold = exp_ctrl[0];
            nscnt[k] = rst ? 64'd0 : scnt[k] + (hold ? 64'd1 : 64'd0);
            nfcnt[k] = rst ? 64'd0 : fcnt[k] + (fl ? 64'd1 : 64'd0);

            act_ctrl = (k == 0) ? {f0, d0, e0, m0, h0} : {f1, d1, e1, m1, h1};
            tests_run++;
            if (act_ctrl !== exp_ctrl) begin
                tests_failed++;
                $display("FAIL %s dut%0d ctrl {f,d,e,m,hold} got=%h expected=%h", tag, k, act_ctrl, exp_ctrl);
            end
            if (counters_valid) begin
`ifdef HAZARD_PERF_EN
                exp_sc = (k == 0) ? scnt[k][31:0] : {28'd0, scnt[k][3:0]};
                exp_fc = (k == 0) ? fcnt[k][31:0] : {28'd0, fcnt[k][3:0]};
`else
                exp_sc = 32'd0;
                exp_fc = 32'd0;
`endif
                act_sc = (k == 0) ? sc0 : {28'd0, sc1};
                act_fc = (k == 0) ? fc0 : {28'd0, fc1};
                tests_run++;
                if (act_sc !== exp_sc || act_fc !== exp_fc) begin
                    tests_failed++;
                    $display("FAIL %s dut%0d counters got=%0d/%0d expected=%0d/%0d", tag, k, act_sc, act_fc, exp_sc, exp_fc);
                end
            end
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            pend[k] = npend[k];
            waiting[k] = nwait[k];
            scnt[k] = nscnt[k];
            fcnt[k] = nfcnt[k];
        end
        @(posedge clk);
        if (rst) counters_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            quiet();
            evaluate("idle");
            advance();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            quiet();
            rst = 1'b1;
            evaluate("reset");
            tests_run++;
            if (f0 !== FLUSH || m1 !== FLUSH || h0 !== 1'b1 || h1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_outputs got f=%0d m=%0d hold=%b%b expected FLUSH/1", f0, m1, h0, h1);
            end
            advance();
        end
        quiet();
        evaluate("post_reset");
        tests_run++;
        if (f1 !== CONTINUE || d1 !== CONTINUE || h1 !== 1'b0 || sc1 !== 4'd0 || fc0 !== 32'd0) begin
            tests_failed++;
            $display("FAIL post_reset got f=%0d d=%0d hold=%b sc=%0d fc=%0d expected CONTINUE/0/0/0", f1, d1, h1, sc1, fc0);
        end
        advance();
    endtask

    task automatic test_load_use_single();
        idle(4);
        quiet();
        mr = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1;
        evaluate("lu1_hit");
        tests_run++;
        if (f0 !== STALL || d0 !== FLUSH || h0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu1_hit got f=%0d d=%0d hold=%b expected STALL/FLUSH/1", f0, d0, h0);
        end
        advance();
        quiet();
        evaluate("lu1_after");
        tests_run++;
        if (f0 !== CONTINUE || h0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu1_after got f=%0d hold=%b expected CONTINUE/0", f0, h0);
        end
        advance();
        idle(4);
        quiet();
        mr = 1'b1; rd = 5'd0; rs2 = 5'd0; u2 = 1'b1; rs1 = 5'd0; u1 = 1'b1;
        evaluate("lu_x0");
        tests_run++;
        if (h0 !== 1'b0 || h1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_x0 got hold=%b%b expected 00", h0, h1);
        end
        advance();
    endtask

    task automatic test_load_use_mem_wait();
        int holds = 0;
        int memflush = 0;
        idle(4);
        for (int c = 0; c < 9; c++) begin
            quiet();
            case (c)
                0: begin mr = 1'b1; rd = 5'd7; rs1 = 5'd7; u1 = 1'b1; end
                1, 2: begin req = 1'b1; rdy = 1'b0; end
                3: begin req = 1'b1; rdy = 1'b1; end
                default: ;
            endcase
            evaluate("lu3_memwait");
            if (h1) holds++;
            if (m1 == FLUSH) memflush++;
            advance();
        end
        tests_run++;
        if (holds != 5) begin
            tests_failed++;
            $display("FAIL lu3_hold_total got=%0d expected=5", holds);
        end
        tests_run++;
        if (memflush != 2) begin
            tests_failed++;
            $display("FAIL lu3_memflush got=%0d expected=2", memflush);
        end
    endtask

    task automatic test_branch_priority();
        quiet();
        rst = 1'b1;
        evaluate("br_reset");
        advance();
        quiet();
        br = 1'b1; mr = 1'b1; rd = 5'd9; rs1 = 5'd9; u1 = 1'b1;
        evaluate("br_lu");
        tests_run++;
        if (f1 !== FLUSH || d1 !== FLUSH || e1 !== CONTINUE || h1 !== 1'b0 || h0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL br_lu got f=%0d d=%0d e=%0d hold=%b%b expected FLUSH/FLUSH/CONTINUE/00", f1, d1, e1, h0, h1);
        end
        advance();
        quiet();
        evaluate("br_after");
        tests_run++;
`ifdef HAZARD_PERF_EN
        if (fc1 !== 4'd1 || h1 !== 1'b0) begin
`else
        if (fc1 !== 4'd0 || h1 !== 1'b0) begin
`endif
            tests_failed++;
            $display("FAIL br_flush_count got fc=%0d hold=%b", fc1, h1);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        idle(4);
        quiet();
        mr = 1'b1; rd = 5'd3; rs2 = 5'd3; u2 = 1'b1;
        evaluate("rms_hit");
        advance();
        quiet();
        evaluate("rms_stall1");
        advance();
        quiet();
        rst = 1'b1;
        evaluate("rms_reset");
        advance();
        for (int i = 0; i < 2; i++) begin
            quiet();
            evaluate("rms_release");
            tests_run++;
            if (h1 !== 1'b0 || f1 !== CONTINUE || st1 !== RUN) begin
                tests_failed++;
                $display("FAIL rms_no_residual got hold=%b f=%0d state=%0d expected 0/CONTINUE/RUN", h1, f1, st1);
            end
            advance();
        end
    endtask

    task automatic test_perf_wrap();
        quiet();
        rst = 1'b1;
        evaluate("wrap_reset");
        advance();
        for (int i = 0; i < 17; i++) begin
            quiet();
            req = 1'b1;
            evaluate("wrap_memwait");
            advance();
        end
        quiet();
        evaluate("wrap_end");
        tests_run++;
`ifdef HAZARD_PERF_EN
        if (sc1 !== 4'd1 || sc0 !== 32'd17) begin
`else
        if (sc1 !== 4'd0 || sc0 !== 32'd0) begin
`endif
            tests_failed++;
            $display("FAIL wrap_stall_count got=%0d/%0d", sc0, sc1);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            quiet();
            rst = ($urandom_range(0, 49) == 0);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 5) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = 1'($urandom_range(0, 1));
            evaluate("random");
            advance();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; waiting[k] = 1'b0; scnt[k] = 0; fcnt[k] = 0;
        end
        quiet();
        rst = 1'b1;
        @(posedge clk);
        counters_valid = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_use_single();
        test_load_use_mem_wait();
        test_branch_priority();
        test_reset_mid_stall();
        test_perf_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Source of the `pipeline_control_t` commands consumed by every pipeline register (fetch→decode, decode→execute, execute→memory, memory→writeback).
- Detects load-use hazards, taken-branch redirects and data-memory wait states.
- Sequences multi-cycle stalls and bubble insertion, and holds the PC.
- Sits beside the datapath in the core top level; one instance per core.

Parameters:
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (legal range 1–3).
- COUNT_WIDTH, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- dec_rs1_i  in  5  rs1 of the instruction in decode
- dec_rs2_i  in  5  rs2 of the instruction in decode
- dec_uses_rs1_i  in  1  decode instruction reads rs1
- dec_uses_rs2_i  in  1  decode instruction reads rs2
- ex_rd_i  in  5  destination register of the instruction in execute
- ex_mem_read_i  in  1  instruction in execute is a load
- ex_branch_taken_i  in  1  execute resolved a taken branch or jump this cycle
- mem_req_i  in  1  memory stage has an access in flight
- mem_ready_i  in  1  data memory completes the access this cycle
- fetch_ctrl_o  out  pipeline_control_t  command for the fetch→decode register
- decode_ctrl_o  out  pipeline_control_t  command for the decode→execute register
- execute_ctrl_o  out  pipeline_control_t  command for the execute→memory register
- memory_ctrl_o  out  pipeline_control_t  command for the memory→writeback register
- pc_hold_o  out  1  PC register keeps its value
- stall_count_o  out  COUNT_WIDTH  stall-cycle counter
- flush_count_o  out  COUNT_WIDTH  flush-event counter

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Output timing: control outputs are combinational from state and inputs; state and counters are registered.
- While rst_i is high:
  - all four ctrl outputs = FLUSH;
  - pc_hold_o = 1;
  - on the next clock edge: state = RUN, stall counter = 0, perf counters = 0.
- Reset asserted mid-stall or mid-wait aborts the stall or wait immediately; no partial state survives.
- States: RUN, LOAD_STALL, MEM_WAIT.
- Hazard definitions:
  - memwait = mem_req_i & ~mem_ready_i.
  - loaduse = ex_mem_read_i & (ex_rd_i != 0) & ((dec_uses_rs1_i & dec_rs1_i == ex_rd_i) | (dec_uses_rs2_i & dec_rs2_i == ex_rd_i)).
  - x0 never causes a hazard.
- Priority, per cycle: memwait > ex_branch_taken_i > loaduse/LOAD_STALL > none.
- memwait, in any state:
  - fetch, decode and execute ctrl = STALL; memory_ctrl = FLUSH (bubble into writeback); pc_hold_o = 1.
  - Next state = MEM_WAIT. The LOAD_STALL remaining count is frozen and saved.
- MEM_WAIT:
  - Exits on the cycle mem_ready_i = 1. That cycle produces the same outputs as RUN evaluation of the current inputs.
  - Next state = LOAD_STALL if the saved count is > 0, else RUN.
- ex_branch_taken_i (no memwait):
  - fetch_ctrl = FLUSH, decode_ctrl = FLUSH, execute and memory ctrl = CONTINUE.
  - pc_hold_o = 0, so the PC loads the target.
  - A branch overrides loaduse: the decode instruction is discarded anyway.
- loaduse in RUN:
  - fetch_ctrl = STALL, decode_ctrl = FLUSH (bubble into execute), execute and memory ctrl = CONTINUE, pc_hold_o = 1.
  - If LOAD_USE_STALLS > 1: next state = LOAD_STALL, counter = LOAD_USE_STALLS−1.
- LOAD_STALL:
  - Same outputs as loaduse, regardless of current inputs. Counter decrements each non-memwait cycle.
  - When the counter reaches 0, next state = RUN.
- Default (RUN, no event): all ctrl = CONTINUE, pc_hold_o = 0.
- Outputs never take any encoding other than CONTINUE, STALL or FLUSH.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_count_o increments on every non-reset cycle with pc_hold_o = 1.
  - flush_count_o increments on every cycle where ex_branch_taken_i wins priority.
  - Both counters wrap modulo 2^COUNT_WIDTH.
- Undefined: both ports exist and are tied to 0; no counter flops.

Decomposition:
- Shared pipeline package (already holding `pipeline_control_t` with CONTINUE/STALL/FLUSH):
  - add `hazard_state_t` {RUN, LOAD_STALL, MEM_WAIT};
  - add a localparam for the x0 register index.
- One sub-module is natural: `load_use_detect`, purely combinational, producing loaduse from the decode and execute fields.

Test Plan:
- Reset: rst_i = 1 for 2 cycles → all ctrl = FLUSH, pc_hold_o = 1. Release → RUN, all CONTINUE, counters 0.
- Load-use, LOAD_USE_STALLS = 1: ex_mem_read_i = 1, ex_rd_i = 5, dec_rs2_i = 5, dec_uses_rs2_i = 1 → one cycle fetch = STALL, decode = FLUSH, pc_hold_o = 1, then CONTINUE. Repeat with ex_rd_i = 0 → no stall.
- Load-use, LOAD_USE_STALLS = 3, with mem_req_i = 1 / mem_ready_i = 0 for 2 cycles during the 2nd stall cycle → 2 MEM_WAIT cycles with memory_ctrl = FLUSH, then the remaining load stall. Total pc_hold_o cycles = 5.
- Branch and load-use in the same cycle (ex_branch_taken_i = 1, loaduse true) → fetch = FLUSH, decode = FLUSH, pc_hold_o = 0. flush_count_o += 1 with HAZARD_PERF_EN.
- Reset asserted in the 2nd cycle of LOAD_STALL (LOAD_USE_STALLS = 3) → next cycle after release is RUN with no residual stall.
- HAZARD_PERF_EN, COUNT_WIDTH = 4: 17 forced memwait cycles → stall_count_o = 1 (wrap).
